mem_port_arbiter: RTL and testbench

Parametrised multi-channel memory front end for the CPU core. It replaces the core's fixed pair of SRAM-style ports (instruction, data) with `NUM_CH` valid/ready request channels arbitrated onto one shared SRAM-style memory port with fixed read latency. Responses are routed back to the issuing channel, and each channel has a flush input that cancels its in-flight responses. It sits between the core pipeline and the top-level SRAM pins.

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the multi-channel memory port arbiter: channel id,
// tracking-pipeline entry and default configuration values.
package mem_arb_pkg;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 1;

    // Channel ids are stored at a fixed width so the entry struct can live here;
    // this bounds NUM_CH to MAX_CH.
    localparam int MAX_CH  = 16;
    localparam int CH_ID_W = $clog2(MAX_CH);

    typedef logic [CH_ID_W-1:0] ch_id_t;

    typedef struct packed {
        logic   live;
        ch_id_t ch_id;
        logic   is_write;
    } pipe_entry_t;

    function automatic ch_id_t onehot_to_id(input logic [MAX_CH-1:0] oh);
        ch_id_t id;
        id = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                id = id | ch_id_t'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter with a registered last-grant pointer.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt
);

    logic found;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`else
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    int               idx;

    // Search starts just above the last winner so every requester is served in turn.
    always_comb begin
        gnt    = '0;
        found  = 1'b0;
        last_d = last_q;
        idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_q) + k) % NUM_CH;
            if (req[idx] && !found) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                last_d   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= IDX_W'(NUM_CH - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// NUM_CH valid/ready request channels sharing one fixed-latency SRAM port,
// with per-channel response routing and flush. Build option: MEM_ARB_FIXED_PRIO_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_req_valid,
    output logic [NUM_CH-1:0]          ch_req_ready,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_req_wen,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_req_wdata,
    input  logic [NUM_CH-1:0]          ch_flush,
    output logic [NUM_CH-1:0]          ch_resp_valid,
    output logic [DATA_W-1:0]          ch_resp_rdata,
    output logic                       mem_en,
    output logic [DATA_W/8-1:0]        mem_wen,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [NUM_CH-1:0] gnt;
    logic              accept;
    ch_id_t            gnt_id;
    pipe_entry_t       pipe_q [RD_LAT];
    pipe_entry_t       pipe_d [RD_LAT];
    pipe_entry_t       head;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (ch_req_valid),
        .gnt   (gnt)
    );

    // Request path is purely combinational: the winner drives the memory pins directly.
    always_comb begin
        accept       = (|gnt) && !reset;
        gnt_id       = onehot_to_id(MAX_CH'(gnt));
        ch_req_ready = reset ? '0 : gnt;
        mem_en       = 1'b0;
        mem_wen      = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (accept) begin
            mem_en = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (gnt[c]) begin
                    mem_wen   = ch_req_wen[c*BE_W +: BE_W];
                    mem_addr  = ch_req_addr[c*ADDR_W +: ADDR_W];
                    mem_wdata = ch_req_wdata[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Entries already in flight lose 'live' when their channel flushes; the
    // entry entering stage 0 this cycle is never affected.
    always_comb begin
        pipe_d[0].live     = accept;
        pipe_d[0].ch_id    = gnt_id;
        pipe_d[0].is_write = accept && (|mem_wen);
        for (int s = 1; s < RD_LAT; s++) begin
            pipe_d[s] = pipe_q[s-1];
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_flush[c] && (pipe_q[s-1].ch_id == ch_id_t'(c))) begin
                    pipe_d[s].live = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

    always_comb begin
        head          = pipe_q[RD_LAT-1];
        ch_resp_valid = '0;
        ch_resp_rdata = '0;
        if (head.live && !reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (head.ch_id == ch_id_t'(c)) begin
                    ch_resp_valid[c] = 1'b1;
                end
            end
            if (!head.is_write) begin
                ch_resp_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3
// share the request inputs; each has its own fixed-latency memory model.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  valid;
    logic [7:0]  wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  flush;

    logic [1:0]  a_ready, b_ready, a_resp_valid, b_resp_valid;
    logic [31:0] a_resp_rdata, b_resp_rdata;
    logic        a_mem_en, b_mem_en;
    logic [3:0]  a_mem_wen, b_mem_wen;
    logic [31:0] a_mem_addr, b_mem_addr, a_mem_wdata, b_mem_wdata;
    logic [31:0] a_mem_rdata, b_mem_rdata;
    logic [31:0] rd_a;
    logic [31:0] rd_b [3];

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut_a (
        .clock(clock), .reset(reset), .ch_req_valid(valid), .ch_req_ready(a_ready),
        .ch_req_wen(wen), .ch_req_addr(addr), .ch_req_wdata(wdata), .ch_flush(flush),
        .ch_resp_valid(a_resp_valid), .ch_resp_rdata(a_resp_rdata), .mem_en(a_mem_en),
        .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut_b (
        .clock(clock), .reset(reset), .ch_req_valid(valid), .ch_req_ready(b_ready),
        .ch_req_wen(wen), .ch_req_addr(addr), .ch_req_wdata(wdata), .ch_flush(flush),
        .ch_resp_valid(b_resp_valid), .ch_resp_rdata(b_resp_rdata), .mem_en(b_mem_en),
        .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    // Clock and memory models
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clock) begin
        rd_a    <= a_mem_en ? mem_val(a_mem_addr) : 32'h0;
        rd_b[0] <= b_mem_en ? mem_val(b_mem_addr) : 32'h0;
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign a_mem_rdata = rd_a;
    assign b_mem_rdata = rd_b[2];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        valid = 2'b11;
        addr  = {32'h0000_0020, 32'h0000_0010};
        tick();
        @(negedge clock);
        checks++; if (a_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_a: got %b expected 00", a_ready); end
        checks++; if (b_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_b: got %b expected 00", b_ready); end
        checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", a_mem_en); end
        checks++; if (a_mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", a_mem_addr); end
        checks++; if (a_resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b expected 00", a_resp_valid); end
        tick();
        reset = 1'b0;
        valid = 2'b00;
        @(negedge clock);
        checks++; if (b_resp_valid !== 2'b00) begin errors++; $display("FAIL post_reset_resp: got %b expected 00", b_resp_valid); end
        tick();
    endtask

    task automatic test_single_read;
        valid       = 2'b01;
        addr[31:0]  = 32'h0000_1000;
        wen         = 8'h00;
        @(negedge clock);
        checks++; if (a_ready !== 2'b01) begin errors++; $display("FAIL read_ready: got %b expected 01", a_ready); end
        checks++; if (a_mem_en !== 1'b1) begin errors++; $display("FAIL read_mem_en: got %b expected 1", a_mem_en); end
        checks++; if (a_mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL read_mem_addr: got %h expected 00001000", a_mem_addr); end
        checks++; if (a_mem_wen !== 4'b0000) begin errors++; $display("FAIL read_mem_wen: got %b expected 0000", a_mem_wen); end
        tick();
        valid = 2'b00;
        @(negedge clock);
        checks++; if (a_resp_valid !== 2'b01) begin errors++; $display("FAIL read_resp_valid: got %b expected 01", a_resp_valid); end
        checks++; if (a_resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_resp_rdata: got %h expected deadbeef", a_resp_rdata); end
        checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL idle_mem_en: got %b expected 0", a_mem_en); end
        checks++; if (a_mem_addr !== 32'h0) begin errors++; $display("FAIL idle_mem_addr: got %h expected 0", a_mem_addr); end
        repeat (3) tick();
    endtask

    task automatic test_write;
        valid        = 2'b10;
        wen          = 8'b0011_0000;
        addr[63:32]  = 32'h0000_2004;
        wdata[63:32] = 32'h0000_ABCD;
        @(negedge clock);
        checks++; if (a_ready !== 2'b10) begin errors++; $display("FAIL write_ready: got %b expected 10", a_ready); end
        checks++; if (a_mem_wen !== 4'b0011) begin errors++; $display("FAIL write_mem_wen: got %b expected 0011", a_mem_wen); end
        checks++; if (a_mem_addr !== 32'h0000_2004) begin errors++; $display("FAIL write_mem_addr: got %h expected 00002004", a_mem_addr); end
        checks++; if (a_mem_wdata !== 32'h0000_ABCD) begin errors++; $display("FAIL write_mem_wdata: got %h expected 0000abcd", a_mem_wdata); end
        tick();
        valid = 2'b00;
        wen   = 8'h00;
        @(negedge clock);
        checks++; if (a_resp_valid !== 2'b10) begin errors++; $display("FAIL write_resp_valid: got %b expected 10", a_resp_valid); end
        checks++; if (a_resp_rdata !== 32'h0) begin errors++; $display("FAIL write_resp_rdata: got %h expected 0", a_resp_rdata); end
        repeat (3) tick();
    endtask

    task automatic test_round_robin;
        logic [1:0]  exp_gnt [4];
        logic [31:0] exp_addr;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        valid = 2'b11;
        addr  = {32'h0000_0204, 32'h0000_0100};
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (k < 4) begin
                exp_addr = (exp_gnt[k] == 2'b01) ? 32'h0000_0100 : 32'h0000_0204;
                checks++; if (a_ready !== exp_gnt[k]) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, a_ready, exp_gnt[k]); end
                checks++; if (a_mem_addr !== exp_addr) begin errors++; $display("FAIL rr_mem_addr[%0d]: got %h expected %h", k, a_mem_addr, exp_addr); end
            end
            if (k > 0) begin
                exp_addr = (exp_gnt[k-1] == 2'b01) ? 32'h0000_0100 : 32'h0000_0204;
                checks++; if (a_resp_valid !== exp_gnt[k-1]) begin errors++; $display("FAIL rr_resp_valid[%0d]: got %b expected %b", k, a_resp_valid, exp_gnt[k-1]); end
                checks++; if (a_resp_rdata !== mem_val(exp_addr)) begin errors++; $display("FAIL rr_resp_rdata[%0d]: got %h expected %h", k, a_resp_rdata, mem_val(exp_addr)); end
            end
            tick();
            if (k == 3) valid = 2'b00;
        end
        repeat (3) tick();
    endtask

    task automatic test_flush;
        logic [1:0]  v_tab    [4];
        logic [31:0] a0_tab   [4];
        logic [1:0]  f_tab    [4];
        logic [1:0]  exp_rv   [7];
        logic [31:0] exp_rd   [7];
        v_tab  = '{2'b01, 2'b01, 2'b10, 2'b01};
        a0_tab = '{32'h300, 32'h304, 32'h0, 32'h308};
        f_tab  = '{2'b00, 2'b00, 2'b00, 2'b01};
        exp_rv = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
        exp_rd = '{32'h0, 32'h0, 32'h0, mem_val(32'h300), 32'h0, mem_val(32'h400), mem_val(32'h308)};
        addr[63:32] = 32'h0000_0400;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                valid      = v_tab[k];
                addr[31:0] = a0_tab[k];
                flush      = f_tab[k];
            end else begin
                valid = 2'b00;
                flush = 2'b00;
            end
            @(negedge clock);
            if (k < 4) begin
                checks++; if (b_ready !== v_tab[k]) begin errors++; $display("FAIL flush_ready[%0d]: got %b expected %b", k, b_ready, v_tab[k]); end
            end
            checks++; if (b_resp_valid !== exp_rv[k]) begin errors++; $display("FAIL flush_resp_valid[%0d]: got %b expected %b", k, b_resp_valid, exp_rv[k]); end
            checks++; if (b_resp_rdata !== exp_rd[k]) begin errors++; $display("FAIL flush_resp_rdata[%0d]: got %h expected %h", k, b_resp_rdata, exp_rd[k]); end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        valid      = 2'b01;
        addr[31:0] = 32'h0000_0500;
        tick();
        valid       = 2'b10;
        addr[63:32] = 32'h0000_0504;
        tick();
        reset = 1'b1;
        valid = 2'b11;
        #1;
        checks++; if (a_ready !== 2'b00 || b_ready !== 2'b00) begin errors++; $display("FAIL mid_reset_ready: got %b/%b expected 00/00", a_ready, b_ready); end
        checks++; if (a_mem_en !== 1'b0 || b_mem_en !== 1'b0) begin errors++; $display("FAIL mid_reset_mem_en: got %b/%b expected 0/0", a_mem_en, b_mem_en); end
        checks++; if (b_mem_addr !== 32'h0) begin errors++; $display("FAIL mid_reset_mem_addr: got %h expected 0", b_mem_addr); end
        checks++; if (a_resp_valid !== 2'b00) begin errors++; $display("FAIL mid_reset_resp_valid: got %b expected 00", a_resp_valid); end
        checks++; if (a_resp_rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_resp_rdata: got %h expected 0", a_resp_rdata); end
        tick();
        reset = 1'b0;
        valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++; if (b_resp_valid !== 2'b00 || a_resp_valid !== 2'b00) begin errors++; $display("FAIL stale_resp[%0d]: got %b/%b expected 00/00", k, a_resp_valid, b_resp_valid); end
            tick();
        end
        valid = 2'b11;
        @(negedge clock);
        checks++; if (a_ready !== 2'b01) begin errors++; $display("FAIL first_grant_a: got %b expected 01", a_ready); end
        checks++; if (b_ready !== 2'b01) begin errors++; $display("FAIL first_grant_b: got %b expected 01", b_ready); end
        tick();
        valid = 2'b00;
        repeat (4) tick();
    endtask

    initial begin
        reset = 1'b1;
        valid = 2'b00;
        wen   = 8'h00;
        addr  = 64'h0;
        wdata = 64'h0;
        flush = 2'b00;
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
